mult_axi_sequencer: RTL
=======================

Name: mult_axi_sequencer

Overview:
- AXI-lite master that runs one full multiply job on the memory-mapped multiplier peripheral: write operand A, write operand B, read the low product word, read the overflow flag.
- A local requester hands it one job at a time over a valid/ready interface and gets product, overflow and error status back.
- Sits between a processing core or test driver and the multiplier slave, and owns the multiplier address map.

Parameters:
- DATA_WIDTH, 32, data bus and operand width
- ADDR_WIDTH, 8, AXI address width
- RESP_WIDTH, 3, BRESP/RRESP width, matching the slave
- ADDR_A, 0, operand A register offset
- ADDR_B, 4, operand B register offset
- ADDR_RES, 8, product low-word register offset
- ADDR_OVF, 12, overflow flag register offset
- TIMEOUT, 64, maximum cycles spent in any single wait state
- RD_SETTLE, 1, cycles after an AR handshake before RVALID is sampled

Ports:
- m2_axi_aclk  in  1  clock
- m2_axi_aresetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  job request
- req_ready  out  1  sequencer idle, job accepted when both high
- req_a  in  DATA_WIDTH  operand A
- req_b  in  DATA_WIDTH  operand B
- res_valid  out  1  result available
- res_ready  in  1  requester consumes result
- res_product  out  DATA_WIDTH  product low word
- res_overflow  out  1  bit 0 of overflow register
- res_err  out  1  timeout or non-zero response seen
- busy  out  1  not IDLE
- m2_axi_awaddr out ADDR_WIDTH; m2_axi_awvalid out 1; m2_axi_awready in 1
- m2_axi_wdata out DATA_WIDTH; m2_axi_wstrb out DATA_WIDTH/8+1 (all ones); m2_axi_wvalid out 1; m2_axi_wready in 1
- m2_axi_bresp in RESP_WIDTH; m2_axi_bvalid in 1; m2_axi_bready out 1
- m2_axi_araddr out ADDR_WIDTH; m2_axi_arvalid out 1; m2_axi_arready in 1
- m2_axi_rdata in DATA_WIDTH; m2_axi_rresp in RESP_WIDTH; m2_axi_rvalid in 1; m2_axi_rready out 1

Behaviour:
- Reset state: state=IDLE. All valid, ready and res_* outputs are 0, and addr/wdata are 0. The reset is asynchronous and deasserts synchronously inside the block.
- Interface: req_ready = (state==IDLE); busy = !req_ready. On the request handshake, req_a and req_b are latched.
- FSM sequence: IDLE -> WR_A -> WB_A -> WR_B -> WB_B -> RD_RES -> RR_RES -> RD_OVF -> RR_OVF -> DONE -> IDLE.
- WR_x:
  - AWVALID and WVALID rise together, with the address and the latched operand.
  - Each valid drops independently the cycle after its own ready is sampled high.
  - The state exits once both handshakes have completed, in either order or in the same cycle.
  - BREADY is held 1 throughout WR_x and WB_x, because the slave samples BREADY during the address/data phase.
- WB_x: waits for BVALID. BRESP != 0 sets the sticky err flag; the sequence continues anyway.
- RD_x:
  - ARVALID is held with the address until ARREADY is sampled.
  - RREADY is held 1 throughout RD_x and RR_x, because the slave requires RREADY together with ARVALID.
- RR_x:
  - Ignores RVALID for RD_SETTLE cycles after the AR handshake; this guards against a slave that holds RVALID high.
  - Then RDATA is captured on the first RVALID: into res_product for RES, and bit 0 into res_overflow for OVF.
  - RRESP != 0 sets err.
- Timeout:
  - A cycle counter clears on every state entry.
  - If it reaches TIMEOUT in any WR/WB/RD/RR state: drop all AXI valids, set err, go to DONE.
  - Registers already captured keep their values. Uncaptured registers are 0.
- DONE:
  - res_valid=1; res_err = err flag.
  - On res_ready, go to IDLE and clear res_valid and err.
  - res_* stay stable while res_valid=1 and res_ready=0.
- Latency: with zero-wait slave handshakes and RD_SETTLE=1, res_valid rises a fixed 10 ±1 cycles after the req handshake. This figure is recorded by the bench as a regression baseline.
- Request blocking: req_valid in any non-IDLE state is not accepted.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no AXI transaction is completed.

Test Plan:
- req_a=3, req_b=5, compliant slave -> writes to 0 and 4, reads from 8 and 12; res_product=15, res_overflow=0, res_err=0.
- req_a=0x00010000, req_b=0x00010000 -> res_product=0x00000000, res_overflow=1, res_err=0.
- Slave holds AWREADY=0 forever, TIMEOUT=64 -> res_valid exactly 64 cycles after entering WR_A; res_err=1; AWVALID=0 in DONE.
- Slave returns BRESP=2 on the operand B write -> sequence completes, product correct, res_err=1.
- res_ready held 0 for 20 cycles after res_valid -> outputs stable and req_ready=0 throughout; a second req_valid is not accepted until the cycle after the res handshake.
- m2_axi_aresetn pulsed low during RR_RES -> all valids/readies 0 immediately (asynchronous); next job 7*6 -> res_product=42.

Source files
------------

// File: rtl/mult_axi_sequencer.sv
// AXI-lite master that runs one multiply job on the multiplier peripheral:
// it writes A, writes B, reads the product low word, then reads the overflow flag.
//   state  | meaning
//   IDLE   | waiting for a job
//   WR_A/B | AW+W issued for operand A/B
//   WB_A/B | waiting for the write response
//   RD_RES | AR issued for the product register
//   RR_RES | waiting for the product read data
//   RD_OVF | AR issued for the overflow register
//   RR_OVF | waiting for the overflow read data
//   DONE   | result presented to the requester
module mult_axi_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int ADDR_A     = 0,
    parameter int ADDR_B     = 4,
    parameter int ADDR_RES   = 8,
    parameter int ADDR_OVF   = 12,
    parameter int TIMEOUT    = 64,
    parameter int RD_SETTLE  = 1
) (
    input  logic                    m2_axi_aclk,
    input  logic                    m2_axi_aresetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH-1:0]   req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_WIDTH-1:0]   res_product,
    output logic                    res_overflow,
    output logic                    res_err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   m2_axi_awaddr,
    output logic                    m2_axi_awvalid,
    input  logic                    m2_axi_awready,
    output logic [DATA_WIDTH-1:0]   m2_axi_wdata,
    output logic [DATA_WIDTH/8:0]   m2_axi_wstrb,
    output logic                    m2_axi_wvalid,
    input  logic                    m2_axi_wready,
    input  logic [RESP_WIDTH-1:0]   m2_axi_bresp,
    input  logic                    m2_axi_bvalid,
    output logic                    m2_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m2_axi_araddr,
    output logic                    m2_axi_arvalid,
    input  logic                    m2_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m2_axi_rdata,
    input  logic [RESP_WIDTH-1:0]   m2_axi_rresp,
    input  logic                    m2_axi_rvalid,
    output logic                    m2_axi_rready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, WR_A, WB_A, WR_B, WB_B, RD_RES, RR_RES, RD_OVF, RR_OVF, DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              rst_sync;
    logic                    rst_int_n;
    logic [CNT_W-1:0]        cnt_q;
    logic                    aw_done_q, w_done_q, err_q;
    logic [DATA_WIDTH-1:0]   op_b_q;
    logic                    aw_hs, w_hs, ar_hs, wr_ok, r_ok, tmo, tmo_exit, state_chg;
    logic                    in_wr, in_wb, in_rd, in_rr;

    // Assert asynchronously, release on a clock edge.
    always_ff @(posedge m2_axi_aclk or negedge m2_axi_aresetn) begin
        if (!m2_axi_aresetn) rst_sync <= 2'b00;
        else                 rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    assign aw_hs     = m2_axi_awvalid && m2_axi_awready;
    assign w_hs      = m2_axi_wvalid && m2_axi_wready;
    assign ar_hs     = m2_axi_arvalid && m2_axi_arready;
    assign wr_ok     = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign r_ok      = (cnt_q >= CNT_W'(RD_SETTLE)) && m2_axi_rvalid;
    assign tmo       = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign state_chg = (state_d != state_q);

    assign in_wr = (state_q == WR_A)   || (state_q == WR_B);
    assign in_wb = (state_q == WB_A)   || (state_q == WB_B);
    assign in_rd = (state_q == RD_RES) || (state_q == RD_OVF);
    assign in_rr = (state_q == RR_RES) || (state_q == RR_OVF);

    always_ff @(posedge m2_axi_aclk or negedge rst_int_n) begin
        if (!rst_int_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        tmo_exit = 1'b0;
        case (state_q)
            IDLE:   if (req_valid)     state_d = WR_A;
            WR_A:   if (wr_ok)         state_d = WB_A;   else tmo_exit = tmo;
            WB_A:   if (m2_axi_bvalid) state_d = WR_B;   else tmo_exit = tmo;
            WR_B:   if (wr_ok)         state_d = WB_B;   else tmo_exit = tmo;
            WB_B:   if (m2_axi_bvalid) state_d = RD_RES; else tmo_exit = tmo;
            RD_RES: if (ar_hs)         state_d = RR_RES; else tmo_exit = tmo;
            RR_RES: if (r_ok)          state_d = RD_OVF; else tmo_exit = tmo;
            RD_OVF: if (ar_hs)         state_d = RR_OVF; else tmo_exit = tmo;
            RR_OVF: if (r_ok)          state_d = DONE;   else tmo_exit = tmo;
            DONE:   if (res_ready)     state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
        if (tmo_exit) state_d = DONE;
    end

    always_ff @(posedge m2_axi_aclk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cnt_q          <= '0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            err_q          <= 1'b0;
            op_b_q         <= '0;
            res_product    <= '0;
            res_overflow   <= 1'b0;
            m2_axi_awvalid <= 1'b0;
            m2_axi_wvalid  <= 1'b0;
            m2_axi_arvalid <= 1'b0;
            m2_axi_awaddr  <= '0;
            m2_axi_wdata   <= '0;
            m2_axi_araddr  <= '0;
        end else begin
            if (state_chg)        cnt_q <= '0;
            else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;

            if (state_q == IDLE && req_valid) begin
                op_b_q       <= req_b;
                res_product  <= '0;
                res_overflow <= 1'b0;
                err_q        <= 1'b0;
            end

            if (state_chg && (state_d == WR_A || state_d == WR_B)) begin
                m2_axi_awvalid <= 1'b1;
                m2_axi_wvalid  <= 1'b1;
                m2_axi_awaddr  <= (state_d == WR_A) ? ADDR_WIDTH'(ADDR_A) : ADDR_WIDTH'(ADDR_B);
                m2_axi_wdata   <= (state_d == WR_A) ? req_a : op_b_q;
                aw_done_q      <= 1'b0;
                w_done_q       <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
                if (m2_axi_awready || state_chg) m2_axi_awvalid <= 1'b0;
                if (m2_axi_wready || state_chg)  m2_axi_wvalid  <= 1'b0;
            end

            if (state_chg && (state_d == RD_RES || state_d == RD_OVF)) begin
                m2_axi_arvalid <= 1'b1;
                m2_axi_araddr  <= (state_d == RD_RES) ? ADDR_WIDTH'(ADDR_RES) : ADDR_WIDTH'(ADDR_OVF);
            end else if (m2_axi_arready || state_chg) begin
                m2_axi_arvalid <= 1'b0;
            end

            if (in_wb && m2_axi_bvalid && m2_axi_bresp != '0) err_q <= 1'b1;
            if (state_q == RR_RES && r_ok) begin
                res_product <= m2_axi_rdata;
                if (m2_axi_rresp != '0) err_q <= 1'b1;
            end
            if (state_q == RR_OVF && r_ok) begin
                res_overflow <= m2_axi_rdata[0];
                if (m2_axi_rresp != '0) err_q <= 1'b1;
            end
            if (tmo_exit)                     err_q <= 1'b1;
            if (state_q == DONE && res_ready) err_q <= 1'b0;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign busy          = !req_ready;
    assign res_valid     = (state_q == DONE);
    assign res_err       = res_valid && err_q;
    // The slave samples BREADY/RREADY alongside the address phase, so hold them across both states.
    assign m2_axi_bready = in_wr || in_wb;
    assign m2_axi_rready = in_rd || in_rr;
    assign m2_axi_wstrb  = '1;

endmodule
